// File: rtl/aes_ahb_regfile_pkg.sv
// Shared types, register offsets and the address-phase error classifier
// for the AES AHB-Lite register file.
package aes_ahb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        ERR1,
        ERR2
    } regfile_state_e;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [7:0] OFF_SRC    = 8'h00;
    localparam logic [7:0] OFF_DST    = 8'h04;
    localparam logic [7:0] OFF_SIZE   = 8'h08;
    localparam logic [7:0] OFF_CTRL   = 8'h0C;
    localparam logic [7:0] OFF_STATUS = 8'h10;
    localparam logic [7:0] OFF_KEY0   = 8'h20;

    // 1 = the transfer must be answered with a two-cycle ERROR response.
    function automatic logic classify_err(
        input logic        hit,
        input logic [7:0]  off,
        input logic [2:0]  size,
        input logic        write,
        input logic        busy,
        input int unsigned key_words
    );
        logic mapped;
        logic guarded;
        case (off)
            OFF_SRC, OFF_DST, OFF_SIZE, OFF_CTRL, OFF_STATUS: mapped = 1'b1;
            default: mapped = (off >= OFF_KEY0) &&
                              (32'(off) < 32'(OFF_KEY0) + key_words * 32'd4) &&
                              (off[1:0] == 2'b00);
        endcase
        // STATUS stays writable while the core runs so software can ack done.
        guarded = mapped && (off != OFF_STATUS);
        return !hit || !mapped || (size != HSIZE_WORD) || (off[1:0] != 2'b00) ||
               (write && busy && guarded);
    endfunction

endpackage

// File: rtl/aes_ahb_regfile_if.sv
// AHB-Lite slave-side bus bundle for the AES register file.
interface aes_ahb_regfile_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  hsel;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic                  hready;
    logic [31:0]           hwdata;
    logic                  hreadyout;
    logic                  hresp;
    logic [31:0]           hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hready, hwdata,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hready, hwdata,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/aes_ahb_regfile.sv
// AHB-Lite register file for the AES accelerator: pointers, size, key, control,
// status/irq, zero-wait legal transfers and two-cycle ERROR responses.
module aes_ahb_regfile
    import aes_ahb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned KEY_WORDS  = 4
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    aes_ahb_regfile_if.slave       bus,
    output logic [31:0]            src_addr,
    output logic [31:0]            dst_addr,
    output logic [31:0]            size_data,
    output logic [32*KEY_WORDS-1:0] key,
    output logic [1:0]             mode,
    output logic                   start,
    input  logic                   core_busy,
    input  logic                   core_done,
    output logic                   irq
);

    if (KEY_WORDS != 4 && KEY_WORDS != 6 && KEY_WORDS != 8) begin : g_bad_key_words
        $fatal(1, "aes_ahb_regfile: KEY_WORDS must be 4, 6 or 8");
    end

    regfile_state_e state_q, state_d;
    logic [7:0]     off_q, off_d;
    logic           wr_q, wr_d;

    logic [31:0] src_q, dst_q, size_q;
    logic [1:0]  mode_q, mode_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic        start_q, start_d;
    logic        irq_q, irq_d;

    logic accept;
    logic win_hit;
    logic addr_err;
    logic wr_en;
    logic status_clr;

    assign accept  = bus.hsel && bus.hready &&
                     (bus.htrans == HTRANS_NONSEQ || bus.htrans == HTRANS_SEQ);
    assign win_hit = (bus.haddr[ADDR_WIDTH-1:8] == BASE_ADDR[ADDR_WIDTH-1:8]);
    assign addr_err = classify_err(win_hit, bus.haddr[7:0], bus.hsize, bus.hwrite,
                                   core_busy, KEY_WORDS);

    // Data phase of a legal write; the target register latches hwdata at its end.
    assign wr_en = (state_q == DATA) && wr_q;

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        wr_d    = wr_q;
        case (state_q)
            ERR1: state_d = ERR2;
            default: begin
                if (accept) begin
                    state_d = addr_err ? ERR1 : DATA;
                    off_d   = bus.haddr[7:0];
                    wr_d    = bus.hwrite;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= IDLE;
            off_q   <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        mode_d     = mode_q;
        irq_en_d   = irq_en_q;
        start_d    = 1'b0;
        status_clr = 1'b0;
        if (wr_en && off_q == OFF_CTRL) begin
            mode_d   = bus.hwdata[1:0];
            irq_en_d = bus.hwdata[3];
            start_d  = bus.hwdata[2];
        end
        if (wr_en && off_q == OFF_STATUS) begin
            status_clr = bus.hwdata[1];
        end
        // A completion landing in the same cycle as the ack must not be lost.
        done_d = core_done || (done_q && !status_clr);
        irq_d  = done_d && irq_en_d;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            src_q    <= '0;
            dst_q    <= '0;
            size_q   <= '0;
            mode_q   <= '0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            start_q  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_en && off_q == OFF_SRC)  src_q  <= bus.hwdata;
            if (wr_en && off_q == OFF_DST)  dst_q  <= bus.hwdata;
            if (wr_en && off_q == OFF_SIZE) size_q <= bus.hwdata;
            mode_q   <= mode_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            start_q  <= start_d;
            irq_q    <= irq_d;
        end
    end

    for (genvar i = 0; i < KEY_WORDS; i++) begin : g_key
        localparam logic [7:0] KeyOff = 8'(32'(OFF_KEY0) + 32'(4 * i));
        logic [31:0] key_q;

        always_ff @(posedge hclk or negedge hresetn) begin
            if (!hresetn) begin
                key_q <= '0;
            end else if (wr_en && off_q == KeyOff) begin
                key_q <= bus.hwdata;
            end
        end

        // KEY[0] is the most significant word of the key bus.
        assign key[32*(KEY_WORDS-i)-1 -: 32] = key_q;
    end

    always_comb begin
        bus.hrdata = '0;
        if (state_q == DATA && !wr_q) begin
            case (off_q)
                OFF_SRC:    bus.hrdata = src_q;
                OFF_DST:    bus.hrdata = dst_q;
                OFF_SIZE:   bus.hrdata = size_q;
                OFF_CTRL:   bus.hrdata = {28'b0, irq_en_q, 1'b0, mode_q};
                OFF_STATUS: bus.hrdata = {30'b0, done_q, core_busy};
                default:    bus.hrdata = '0;
            endcase
        end
    end

    always_comb begin
        bus.hreadyout = 1'b1;
        bus.hresp     = 1'b0;
        case (state_q)
            ERR1: begin
                bus.hreadyout = 1'b0;
                bus.hresp     = 1'b1;
            end
            ERR2: bus.hresp = 1'b1;
            default: ;
        endcase
    end

    assign src_addr  = src_q;
    assign dst_addr  = dst_q;
    assign size_data = size_q;
    assign mode      = mode_q;
    assign start     = start_q;
    assign irq       = irq_q;

endmodule
